// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: time-multiplexed controller for a symmetric 31-tap FIR filter.
// A single multiplier is stepped across the 16 coefficient slots, one slot per cycle.
// The block owns the circular sample history and the run-time coefficient table.
//
// Build option: FIR_SAT_EN
//   defined   - the rounded result clamps to 2^DATA_W-1 when it is too large
//   undefined - the rounded result keeps only its low DATA_W bits (wraps)
//
// Handshakes:
//   Input : a sample is taken on a rising edge where in_valid && in_ready. in_ready is
//           high only in IDLE, and in_sample is ignored whenever in_ready is low.
//   Output: out_valid is a one-cycle pulse with no back-pressure. out_sample changes
//           only when a new result is produced and holds until the next pulse.
//   Coef  : coef_we is a single-cycle strobe. A write is taken only in IDLE with an
//           in-range slot. Any other write is dropped, and coef_err pulses one cycle later.
module fir_mac_scheduler #(
    parameter int DATA_W = 10,
    parameter int COEF_W = 12,
    parameter int NTAPS  = 31,
    parameter int ACC_W  = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sample,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sample,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_err,
    output logic              busy
);

    localparam int NPAIR  = (NTAPS + 1) / 2;
    localparam int PTR_W  = $clog2(NTAPS);
    localparam int K_W    = $clog2(NPAIR);
    // The table carries one extra bit so that slot 15 can reset to exactly 1.0 (4096).
    localparam int CTAB_W = COEF_W + 1;
    localparam int PAIR_W = DATA_W + 1;
    localparam int PROD_W = CTAB_W + PAIR_W;
    localparam int Q_W    = ACC_W - COEF_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  head;
    logic [K_W-1:0]    k;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] hist [NTAPS];
    logic [CTAB_W-1:0] coef [NPAIR];

    // Subtract modulo NTAPS on PTR_W-bit pointers. Fold back by NTAPS when the difference is negative.
    function automatic logic [PTR_W-1:0] sub_mod(input logic [PTR_W-1:0] a,
                                                 input logic [PTR_W-1:0] b);
        logic [PTR_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[PTR_W]) begin
            d = d + (PTR_W + 1)'(NTAPS);
        end
        return d[PTR_W-1:0];
    endfunction

    logic              is_idle;
    logic              accept;
    logic              addr_ok;
    logic              coef_take;
    logic              is_centre;
    logic [PTR_W-1:0]  k_ptr;
    logic [PTR_W-1:0]  k_far;
    logic [PTR_W-1:0]  idx_near;
    logic [PTR_W-1:0]  idx_far;
    logic [PAIR_W-1:0] pair;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  rnd;
    logic [Q_W-1:0]    q;
    logic [DATA_W-1:0] fmt_val;

    assign is_idle   = (state == ST_IDLE);
    assign accept    = is_idle && in_valid;
    assign addr_ok   = ({1'b0, coef_addr} < 5'(NPAIR));
    assign coef_take = coef_we && is_idle && addr_ok;

    // Slot k pairs the tap k samples back with the tap (NTAPS-1-k) samples back.
    assign is_centre = (k == K_W'(NPAIR - 1));
    assign k_ptr     = PTR_W'(k);
    assign k_far     = PTR_W'(NTAPS - 1) - k_ptr;
    assign idx_near  = sub_mod(head, k_ptr);
    assign idx_far   = sub_mod(head, k_far);

    // Build the pre-added pair and apply the slot coefficient. The centre tap is counted once.
    always_comb begin
        pair = {1'b0, hist[idx_near]};
        if (!is_centre) begin
            pair = pair + {1'b0, hist[idx_far]};
        end
        prod     = PROD_W'(coef[k]) * PROD_W'(pair);
        acc_next = acc + ACC_W'(prod);
    end

    // Round half up, drop the Q0.COEF_W fraction, then narrow to the output width.
    always_comb begin
        rnd = acc_next + ACC_W'(2 ** (COEF_W - 1));
        q   = rnd[ACC_W-1:COEF_W];
`ifdef FIR_SAT_EN
        if (q > Q_W'(2 ** DATA_W - 1)) begin
            fmt_val = '1;
        end else begin
            fmt_val = q[DATA_W-1:0];
        end
`else
        fmt_val = q[DATA_W-1:0];
`endif
    end

    // These fraction bits are below the output resolution by design.
    logic unused_frac;
    assign unused_frac = ^rnd[COEF_W-1:0];
`ifndef FIR_SAT_EN
    // In wrap mode the integer bits above DATA_W are discarded on purpose.
    logic unused_high;
    assign unused_high = ^q[Q_W-1:DATA_W];
`endif

    // Sequencer: accept a sample, step through the slots, and publish the result for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            head       <= '0;
            k          <= '0;
            acc        <= '0;
            out_sample <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        head   <= wr_ptr;
                        wr_ptr <= (wr_ptr == PTR_W'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
                        acc    <= '0;
                        k      <= '0;
                        state  <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    if (is_centre) begin
                        out_sample <= fmt_val;
                        state      <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Circular sample history: the accepted sample is written at the current write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                hist[i] <= '0;
            end
        end else if (accept) begin
            hist[wr_ptr] <= in_sample;
        end
    end

    // Coefficient table. It resets to a pure delay of NPAIR-1 samples (only the centre slot is 1.0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPAIR; i++) begin
                coef[i] <= '0;
            end
            coef[NPAIR-1] <= CTAB_W'(2 ** COEF_W);
        end else if (coef_take) begin
            coef[coef_addr] <= {1'b0, coef_data};
        end
    end

    // Report a dropped coefficient write one cycle after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coef_err <= 1'b0;
        end else begin
            coef_err <= coef_we && !coef_take;
        end
    end

    assign in_ready  = is_idle;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_MAC) || (state == ST_DONE);

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler.
// The reference model is a direct-form 31-tap convolution over every sample accepted
// since the last reset. It uses the symmetric tap weights h[j] = c[min(j, 30-j)] and the
// same rounding and narrowing rule as the design (FIR_SAT_EN selects clamp or wrap).
module tb_fir_mac_scheduler;

    localparam int DATA_W = 10;
    localparam int COEF_W = 12;
    localparam int NTAPS  = 31;
    localparam int NPAIR  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sample;
    logic              out_valid;
    logic [DATA_W-1:0] out_sample;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              coef_err;
    logic              busy;

    fir_mac_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_err   (coef_err),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];
    int unsigned       hist_q[$];
    int unsigned       c_m[NPAIR];
    logic [DATA_W-1:0] last_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        hist_q.delete();
        exp_q.delete();
        for (int i = 0; i < NPAIR; i++) c_m[i] = 0;
        c_m[NPAIR-1] = 4096;
    endfunction

    function automatic logic [DATA_W-1:0] model_y();
        longint unsigned a = 0;
        longint unsigned r;
        int n = hist_q.size();
        for (int j = 0; j < NTAPS; j++) begin
            int unsigned x = (j < n) ? hist_q[n-1-j] : 0;
            int unsigned h = (j < NPAIR) ? c_m[j] : c_m[NTAPS-1-j];
            a += longint'(h) * longint'(x);
        end
        r = (a + 2048) >> COEF_W;
`ifdef FIR_SAT_EN
        if (r > 1023) r = 1023;
`endif
        return DATA_W'(r);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [COEF_W-1:0] d);
        coef_we = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
        c_m[a] = d;
        check("coef_err_idle_write", coef_err, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("ready_before_send", in_ready, 1);
    endtask

    // Send one sample (optionally with a same-edge coefficient write).
    // Then check the result pulse: DONE follows edge E16, and IDLE returns after E17.
    task automatic send(input logic [DATA_W-1:0] s, input bit wr,
                        input logic [3:0] a, input logic [COEF_W-1:0] d);
        int n;
        wait_idle();
        in_valid = 1'b1;
        in_sample = s;
        if (wr) begin
            coef_we = 1'b1;
            coef_addr = a;
            coef_data = d;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        coef_we = 1'b0;
        in_sample = DATA_W'($urandom_range(0, 1023));
        if (wr) c_m[a] = d;
        hist_q.push_back(s);
        exp_q.push_back(model_y());
        check("busy_after_accept", busy, 1);
        check("ready_low_after_accept", in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("out_latency_edges", n, 16);
        if (out_valid === 1'b1) begin
            last_out = out_sample;
            check("out_sample", out_sample, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        check("out_valid_one_cycle", out_valid, 0);
        check("ready_after_done", in_ready, 1);
    endtask

    // ---------------- directed steps ----------------
    int acc_cyc[$];
    int viol;
    int hits;
    logic [DATA_W-1:0] exp3;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        last_out = '0;
        model_reset();
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sample", out_sample, 0);
        check("reset_coef_err", coef_err, 0);
        check("reset_busy", busy, 0);
        do_reset();

        // 1: reset coefficients act as a 15-sample delay
        for (int i = 1; i <= 20; i++) begin
            send(DATA_W'(i), 1'b0, 4'd0, '0);
            if (i <= 15) check("t1_leading_zero", last_out, 0);
            if (i == 16) check("t1_16th_output", last_out, 1);
            if (i == 20) check("t1_20th_output", last_out, 5);
        end

        // 2: flat 128 coefficients, full-scale input
        do_reset();
        for (int i = 0; i < NPAIR; i++) write_coef(4'(i), 12'd128);
        for (int i = 0; i < 31; i++) send(10'd1023, 1'b0, 4'd0, '0);
        check("t2_31st_output", last_out, 991);

        // 3: maximum coefficients overflow the output range
        do_reset();
        for (int i = 0; i < NPAIR; i++) write_coef(4'(i), 12'd4095);
        for (int i = 0; i < 31; i++) send(10'd1023, 1'b0, 4'd0, '0);
`ifdef FIR_SAT_EN
        exp3 = 10'd1023;
`else
        exp3 = 10'd985;
`endif
        check("t3_31st_output", last_out, 32'(exp3));

        // random coefficients and samples, with occasional same-edge writes
        do_reset();
        for (int i = 0; i < NPAIR; i++) write_coef(4'(i), 12'($urandom_range(0, 4095)));
        for (int i = 0; i < 40; i++) begin
            send(DATA_W'($urandom_range(0, 1023)), ($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
        end

        // 4: in_valid held high -> accepts every 18 cycles, busy between
        viol = 0;
        acc_cyc.delete();
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            in_sample = DATA_W'($urandom_range(0, 1023));
            if (busy === in_ready) viol++;
            if (in_ready === 1'b1) begin
                acc_cyc.push_back(cyc);
                hist_q.push_back(in_sample);
                exp_q.push_back(model_y());
            end
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) check("t4_out_sample", out_sample, exp_q.pop_front());
        end
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) check("t4_drain_out_sample", out_sample, exp_q.pop_front());
        end
        check("t4_ready_busy_exclusive_violations", viol, 0);
        check("t4_accept_count", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("t4_accept_spacing", acc_cyc[i] - acc_cyc[i-1], 18);
        check("t4_outputs_pending", exp_q.size(), 0);

        // 5: coefficient writes outside IDLE are dropped
        do_reset();
        for (int i = 0; i < 20; i++) send(DATA_W'($urandom_range(1, 1023)), 1'b0, 4'd0, '0);
        wait_idle();
        in_valid = 1'b1;
        in_sample = DATA_W'($urandom_range(1, 1023));
        @(posedge clk);
        #1 in_valid = 1'b0;
        hist_q.push_back(in_sample);
        exp_q.push_back(model_y());
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        coef_we = 1'b1;
        coef_addr = 4'd3;
        coef_data = 12'd99;
        @(posedge clk);
        #1 coef_we = 1'b0;
        check("t5_coef_err_mac", coef_err, 1);
        coef_addr = 4'd15;
        coef_data = 12'd0;
        coef_we = 1'b1;
        @(posedge clk);
        #1 coef_we = 1'b0;
        check("t5_coef_err_mac_centre", coef_err, 1);
        @(posedge clk);
        #1;
        check("t5_coef_err_clears", coef_err, 0);
        hits = 0;
        while (out_valid !== 1'b1 && hits < 40) begin
            @(posedge clk);
            #1 hits++;
        end
        check("t5_out_valid_seen", out_valid, 1);
        check("t5_out_sample", out_sample, exp_q.pop_front());
        coef_we = 1'b1;
        coef_addr = 4'd15;
        coef_data = 12'd0;
        @(posedge clk);
        #1 coef_we = 1'b0;
        check("t5_coef_err_done", coef_err, 1);
        for (int i = 0; i < 4; i++) send(DATA_W'($urandom_range(1, 1023)), 1'b0, 4'd0, '0);

        // 6: reset in the middle of MAC (slot k=7) abandons the operation
        wait_idle();
        in_valid = 1'b1;
        in_sample = DATA_W'($urandom_range(1, 1023));
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("t6_busy_before_reset", busy, 1);
        reset = 1'b1;
        #1;
        check("t6_reset_out_valid", out_valid, 0);
        check("t6_reset_in_ready", in_ready, 1);
        check("t6_reset_out_sample", out_sample, 0);
        check("t6_reset_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        hits = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) hits++;
        end
        check("t6_no_out_valid", hits, 0);
        check("t6_in_ready_after", in_ready, 1);
        check("t6_out_sample_after", out_sample, 0);
        for (int i = 0; i < 17; i++) send(DATA_W'($urandom_range(0, 1023)), 1'b0, 4'd0, '0);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
